s_inv_cms_pipe: RTL and testbench

// - First-order CMS-masked PRINCE inverse S-box, 2-share in / 2-share out, NSB nibbles in parallel.
// - Counterpart of the forward masked S-box datapath; used in the decryption rounds and in the

---
 rtl/s_inv_cms_pipe_if.sv | 27 ++
 rtl/s_inv_cms_pipe.sv | 136 +++++++++++++
 tb/tb_s_inv_cms_pipe.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/s_inv_cms_pipe_if.sv
// Handshake bundle for the masked PRINCE inverse S-box pipeline.
// The master drives the input shares and pulls the results; the slave is the S-box.
interface s_inv_cms_pipe_if #(
  parameter int NSB = 1
);
  localparam int RAND_W = 32 * NSB;

  logic              in_valid;
  logic              in_ready;
  logic [4*NSB-1:0]  in_sh0;
  logic [4*NSB-1:0]  in_sh1;
  logic [RAND_W-1:0] rnd;
  logic              out_valid;
  logic              out_ready;
  logic [4*NSB-1:0]  out_sh0;
  logic [4*NSB-1:0]  out_sh1;

  modport master (
    output in_valid, in_sh0, in_sh1, rnd, out_ready,
    input  in_ready, out_valid, out_sh0, out_sh1
  );

  modport slave (
    input  in_valid, in_sh0, in_sh1, rnd, out_ready,
    output in_ready, out_valid, out_sh0, out_sh1
  );
endinterface

// File: rtl/s_inv_cms_pipe.sv
// First-order CMS-masked PRINCE inverse S-box: 2 shares -> 8 refreshed shares (stage 1)
// -> 2 shares (stage 2), NSB nibbles in parallel, valid/ready with full backpressure.
module s_inv_cms_pipe #(
  parameter int NSB = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  s_inv_cms_pipe_if.slave  io
);
  localparam int RAND_W = 32 * NSB;
  // Sinv truth table, nibble x at bits [4x+3:4x]
  localparam logic [63:0] SINV = 64'h1CE5_046A_98DF_237B;

  // Share index used for each input bit by output share k = 4i+2j+l:
  // x0 -> i, x1 -> j, x2 -> l, x3 -> i^j^l. Any three coordinates of these eight
  // vectors are all distinct, so every degree<=3 monomial has a home for each of
  // its share combinations while each k still sees only one share per input bit.
  function automatic logic [3:0] sigma(input int k);
    logic [2:0] kb;
    kb = k[2:0];
    return {^kb, kb[0], kb[1], kb[2]};
  endfunction

  // Lower-degree terms match several k; only the lowest such k takes the term.
  function automatic logic owner(input int m, input int k);
    logic [3:0] mm;
    logic       own;
    mm  = m[3:0];
    own = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j < k && ((sigma(j) ^ sigma(k)) & mm) == 4'b0000) own = 1'b0;
    end
    return own;
  endfunction

  // Algebraic normal form of each Sinv coordinate (Moebius transform of the table).
  function automatic logic [3:0][15:0] anf_table();
    logic [3:0][15:0] t;
    for (int b = 0; b < 4; b++) begin
      for (int x = 0; x < 16; x++) t[b][x] = SINV[4*x+b];
      for (int v = 0; v < 4; v++) begin
        for (int m = 0; m < 16; m++) begin
          if (m[v]) t[b][m] = t[b][m] ^ t[b][m ^ (1 << v)];
        end
      end
    end
    return t;
  endfunction

  localparam logic [3:0][15:0] ANF = anf_table();

  // Expanded share e[b][k]; sg is a constant, so sel is pure wiring of one share per bit.
  function automatic logic e_bit(input logic [3:0] a0, input logic [3:0] a1,
                                 input int b, input int k);
    logic [3:0] sg;
    logic [3:0] sel;
    logic       acc;
    logic       term;
    sg  = sigma(k);
    sel = (a0 & ~sg) | (a1 & sg);
    acc = 1'b0;
    for (int m = 0; m < 16; m++) begin
      if (ANF[b][m] && owner(m, k)) begin
        term = 1'b1;
        for (int v = 0; v < 4; v++) begin
          if (m[v]) term = term & sel[v];
        end
        acc = acc ^ term;
      end
    end
    return acc;
  endfunction

  logic [RAND_W-1:0] f;

  for (genvar n = 0; n < NSB; n++) begin : g_nib
    for (genvar b = 0; b < 4; b++) begin : g_bit
      for (genvar k = 0; k < 8; k++) begin : g_sh
        assign f[32*n+8*b+k] = e_bit(io.in_sh0[4*n +: 4], io.in_sh1[4*n +: 4], b, k)
                             ^ io.rnd[32*n+8*b+k] ^ io.rnd[32*n+8*b+((k+1)%8)];
      end
    end
  end

  logic              s1_valid_q, s1_valid_d;
  logic              s2_valid_q, s2_valid_d;
  logic [RAND_W-1:0] s1_f_q, s1_f_d;
  logic [4*NSB-1:0]  s2_sh0_q, s2_sh0_d;
  logic [4*NSB-1:0]  s2_sh1_q, s2_sh1_d;
  logic              s2_adv, s1_adv, accept, s2_load;

  always_comb begin
    s2_adv     = !s2_valid_q || io.out_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    accept     = io.in_valid && s1_adv;
    s2_load    = s1_valid_q && s2_adv;

    s1_valid_d = accept || (s1_valid_q && !s2_load);
    s1_f_d     = accept ? f : s1_f_q;
    s2_valid_d = s2_load || (s2_valid_q && !io.out_ready);

    // NOTE: every comb output gets a default before the conditional update, else a latch is inferred.
    s2_sh0_d   = s2_sh0_q;
    s2_sh1_d   = s2_sh1_q;
    if (s2_load) begin
      for (int n = 0; n < NSB; n++) begin
        for (int b = 0; b < 4; b++) begin
          s2_sh0_d[4*n+b] = ^s1_f_q[32*n+8*b   +: 4];
          s2_sh1_d[4*n+b] = ^s1_f_q[32*n+8*b+4 +: 4];
        end
      end
    end
  end

  // NOTE: share registers are reset too, so no stale masked data survives a reset; state uses <= only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_f_q     <= '0;
      s2_sh0_q   <= '0;
      s2_sh1_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_f_q     <= s1_f_d;
      s2_sh0_q   <= s2_sh0_d;
      s2_sh1_q   <= s2_sh1_d;
    end
  end

  assign io.in_ready  = s1_adv;
  assign io.out_valid = s2_valid_q;
  assign io.out_sh0   = s2_sh0_q;
  assign io.out_sh1   = s2_sh1_q;
endmodule

// File: tb/tb_s_inv_cms_pipe.sv
// Directed bench for s_inv_cms_pipe: reset, exhaustive function, fixed-rnd cases,
// backpressure, back-to-back streaming, mid-operation reset and a 4-nibble instance.
module tb_s_inv_cms_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  s_inv_cms_pipe_if #(.NSB(1)) io ();
  s_inv_cms_pipe_if #(.NSB(4)) io4 ();

  s_inv_cms_pipe #(.NSB(1)) u_dut  (.clk(clk), .rst_n(rst_n), .io(io));
  s_inv_cms_pipe #(.NSB(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .io(io4));

  logic [3:0] sinv_ref [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                                4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [3:0] x_list [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [3:0] x);
    io.in_valid = 1'b1;
    io.in_sh0   = 4'($urandom);
    io.in_sh1   = io.in_sh0 ^ x;
    io.rnd      = $urandom;
  endtask

  // Single transaction on an empty pipe; result must appear exactly 2 cycles later.
  task automatic one_shot(input string tag, input logic [3:0] x,
                          input logic [3:0] sh0, input logic [31:0] r);
    io.out_ready = 1'b1;
    io.in_valid  = 1'b1;
    io.in_sh0    = sh0;
    io.in_sh1    = sh0 ^ x;
    io.rnd       = r;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(io.in_ready), 32'd1);
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    io.in_sh0   = 4'($urandom);
    io.in_sh1   = 4'($urandom);
    io.rnd      = $urandom;
    @(negedge clk);
    check({tag, "_lat1_valid"}, 32'(io.out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_valid"}, 32'(io.out_valid), 32'd1);
    check(tag, 32'(io.out_sh0 ^ io.out_sh1), 32'(sinv_ref[x]));
    @(posedge clk); #1;
  endtask

  // Streams x_list; out_ready held low for the first 'stall' cycles.
  task automatic stream(input string tag, input int stall);
    logic [3:0] exp_q [$];
    int idx = 0, got = 0, cyc = 0, first = -1, last = -1, n;
    logic acc;
    n = x_list.size();
    io.out_ready = (stall == 0);
    present(x_list[0]);
    while (got < n && cyc < 4*n + stall + 10) begin
      @(negedge clk);
      if (io.out_valid && io.out_ready) begin
        if (exp_q.size() == 0) check({tag, "_spurious_valid"}, 32'(io.out_valid), 32'd0);
        else check(tag, 32'(io.out_sh0 ^ io.out_sh1), 32'(exp_q.pop_front()));
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (stall > 0 && cyc >= 2 && cyc < stall) begin
        check({tag, "_stall_in_ready"}, 32'(io.in_ready), 32'd0);
        check({tag, "_stall_valid"}, 32'(io.out_valid), 32'd1);
        check({tag, "_stall_data"}, 32'(io.out_sh0 ^ io.out_sh1), 32'(sinv_ref[x_list[0]]));
      end
      acc = io.in_valid && io.in_ready;
      if (acc) exp_q.push_back(sinv_ref[x_list[idx]]);
      @(posedge clk); #1;
      if (acc) idx++;
      if (idx < n) begin
        if (acc) present(x_list[idx]);
      end else begin
        io.in_valid = 1'b0;
      end
      if (cyc + 1 >= stall) io.out_ready = 1'b1;
      cyc++;
    end
    check({tag, "_count"}, 32'(got), 32'(n));
    if (stall == 0) begin
      check({tag, "_latency"}, 32'(first), 32'd2);
      check({tag, "_no_bubble"}, 32'(last - first), 32'(n - 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    io.in_valid   = 1'b0;
    io.in_sh0     = '0;
    io.in_sh1     = '0;
    io.rnd        = '0;
    io.out_ready  = 1'b1;
    io4.in_valid  = 1'b0;
    io4.in_sh0    = '0;
    io4.in_sh1    = '0;
    io4.rnd       = '0;
    io4.out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_out_valid", 32'(io.out_valid), 32'd0);
    check("rst_out_sh0", 32'(io.out_sh0), 32'd0);
    check("rst_out_sh1", 32'(io.out_sh1), 32'd0);
    check("rst_in_ready", 32'(io.in_ready), 32'd1);
    check("rst4_out_valid", 32'(io4.out_valid), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Named corner values
    one_shot("x0_to_B", 4'h0, 4'h9, $urandom);
    one_shot("x4_to_F", 4'h4, 4'h3, $urandom);
    one_shot("xF_to_1", 4'hF, 4'hC, $urandom);

    // Fixed randomness: x = A with rnd all-zero and all-one
    one_shot("rnd0_xA", 4'hA, 4'h0, 32'h0000_0000);
    one_shot("rnd1_xA", 4'hA, 4'h0, 32'hFFFF_FFFF);

    // Exhaustive, back-to-back
    x_list.delete();
    for (int i = 0; i < 16; i++) x_list.push_back(4'(i));
    stream("exh", 0);

    // Backpressure: 4 inputs, out_ready low for 5 cycles
    x_list.delete();
    x_list.push_back(4'h3);
    x_list.push_back(4'h8);
    x_list.push_back(4'hC);
    x_list.push_back(4'h6);
    stream("bp", 5);

    // 100 random back-to-back
    x_list.delete();
    for (int i = 0; i < 100; i++) x_list.push_back(4'($urandom));
    stream("b2b", 0);

    // Reset with both stages full
    io.out_ready = 1'b0;
    present(4'h3);
    @(posedge clk); #1;
    present(4'hC);
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    @(negedge clk);
    check("full_out_valid", 32'(io.out_valid), 32'd1);
    check("full_in_ready", 32'(io.in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(io.out_valid), 32'd0);
    check("midrst_out_sh0", 32'(io.out_sh0), 32'd0);
    check("midrst_out_sh1", 32'(io.out_sh1), 32'd0);
    check("midrst_in_ready", 32'(io.in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    one_shot("post_rst_x7", 4'h7, 4'h5, $urandom);

    // Four nibbles in parallel: {F,A,5,0} -> {1,4,D,B}
    io4.in_valid = 1'b1;
    io4.in_sh0   = 16'($urandom);
    io4.in_sh1   = io4.in_sh0 ^ 16'hFA50;
    io4.rnd      = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    io4.in_valid = 1'b0;
    @(negedge clk);
    check("nsb4_lat1_valid", 32'(io4.out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("nsb4_valid", 32'(io4.out_valid), 32'd1);
    check("nsb4_data", 32'(io4.out_sh0 ^ io4.out_sh1), 32'h0000_14DB);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
